// File: rtl/woi_pkg.sv
// Shared defaults and helpers for the multi-window region-of-interest detector.
package woi_pkg;

    localparam int unsigned NumWinDefault = 4;
    localparam int unsigned MaxWin        = 8;
    localparam int unsigned CwDefault     = 12;
    localparam int unsigned FwDefault     = 16;

    typedef logic [$clog2(MaxWin)-1:0] win_idx_t;

    // LSB of window idx inside a packed NUM_WIN*cw coordinate bus.
    function automatic int unsigned coord_lsb(input int unsigned idx, input int unsigned cw);
        return idx * cw;
    endfunction

endpackage

// File: rtl/woi_det_multi_if.sv
// Video timing, window configuration and per-window result bundle for woi_det_multi.
interface woi_det_multi_if
    import woi_pkg::*;
#(
    parameter int unsigned NUM_WIN = NumWinDefault,
    parameter int unsigned CW      = CwDefault,
    parameter int unsigned FW      = FwDefault
);

    logic                  vblank;
    logic                  hblank;
    logic [NUM_WIN*CW-1:0] cfg_x0;
    logic [NUM_WIN*CW-1:0] cfg_x1;
    logic [NUM_WIN*CW-1:0] cfg_y0;
    logic [NUM_WIN*CW-1:0] cfg_y1;
    logic [NUM_WIN-1:0]    cfg_en;
    logic                  cfg_load;
    logic                  cfg_pending;
    logic [NUM_WIN-1:0]    win_active;
    logic [NUM_WIN-1:0]    win_sow;
    logic [NUM_WIN-1:0]    win_eol;
    logic [NUM_WIN-1:0]    win_eow;
    logic [NUM_WIN*CW-1:0] win_x;
    logic [NUM_WIN*CW-1:0] win_y;
    logic [NUM_WIN-1:0]    cfg_err;
    logic [FW-1:0]         frame_cnt;

    modport master (
        output vblank, hblank, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_en, cfg_load,
        input  cfg_pending, win_active, win_sow, win_eol, win_eow, win_x, win_y, cfg_err,
        input  frame_cnt
    );

    modport slave (
        input  vblank, hblank, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_en, cfg_load,
        output cfg_pending, win_active, win_sow, win_eol, win_eow, win_x, win_y, cfg_err,
        output frame_cnt
    );

endinterface

// File: rtl/woi_win_cmp.sv
// One detection window: shadow geometry, stage-1 compares and stage-2 registered strobes.
module woi_win_cmp
    import woi_pkg::*;
#(
    parameter int unsigned CW = CwDefault
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] cfg_x0_i,
    input  logic [CW-1:0] cfg_x1_i,
    input  logic [CW-1:0] cfg_y0_i,
    input  logic [CW-1:0] cfg_y1_i,
    input  logic          cfg_en_i,
    input  logic          active_i,
    input  logic [CW-1:0] col_i,
    input  logic [CW-1:0] row_i,
    input  logic [CW-1:0] col1_i,
    input  logic [CW-1:0] row1_i,
    output logic          win_active_o,
    output logic          win_sow_o,
    output logic          win_eol_o,
    output logic          win_eow_o,
    output logic [CW-1:0] win_x_o,
    output logic [CW-1:0] win_y_o,
    output logic          cfg_err_o
);

    logic [CW-1:0] x0_q, x1_q, y0_q, y1_q;
    logic          en_q;
    logic          err_q;
    logic          err_c;
    logic          hit_c;
    logic          hit1_q, sow1_q, eol1_q, eow1_q;
    logic          act2_q, sow2_q, eol2_q, eow2_q;
    logic [CW-1:0] x2_q, y2_q;

    // Gate on the live shadow check so a freshly loaded bad window never hits.
    assign err_c = (x0_q > x1_q) | (y0_q > y1_q);
    assign hit_c = active_i & en_q & ~err_c & (col_i >= x0_q) & (col_i <= x1_q)
                 & (row_i >= y0_q) & (row_i <= y1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q   <= '0;
            x1_q   <= '0;
            y0_q   <= '0;
            y1_q   <= '0;
            en_q   <= 1'b0;
            err_q  <= 1'b0;
            hit1_q <= 1'b0;
            sow1_q <= 1'b0;
            eol1_q <= 1'b0;
            eow1_q <= 1'b0;
            act2_q <= 1'b0;
            sow2_q <= 1'b0;
            eol2_q <= 1'b0;
            eow2_q <= 1'b0;
            x2_q   <= '0;
            y2_q   <= '0;
        end else begin
            if (load_i) begin
                x0_q <= cfg_x0_i;
                x1_q <= cfg_x1_i;
                y0_q <= cfg_y0_i;
                y1_q <= cfg_y1_i;
                en_q <= cfg_en_i;
            end
            err_q  <= err_c;
            hit1_q <= hit_c;
            sow1_q <= hit_c & (col_i == x0_q) & (row_i == y0_q);
            eol1_q <= hit_c & (col_i == x1_q);
            eow1_q <= hit_c & (col_i == x1_q) & (row_i == y1_q);
            // Shadow only reloads in vblank, so x0/y0 still match the stage-1 pixel here.
            act2_q <= hit1_q;
            sow2_q <= sow1_q;
            eol2_q <= eol1_q;
            eow2_q <= eow1_q;
            x2_q   <= hit1_q ? col1_i - x0_q : '0;
            y2_q   <= hit1_q ? row1_i - y0_q : '0;
        end
    end

    assign win_active_o = act2_q;
    assign win_sow_o    = sow2_q;
    assign win_eol_o    = eol2_q;
    assign win_eow_o    = eow2_q;
    assign win_x_o      = x2_q;
    assign win_y_o      = y2_q;
    assign cfg_err_o    = err_q;

endmodule

// File: rtl/woi_det_multi.sv
// Multi-window ROI detector: pixel/row counters, frame counter and frame-aligned shadow
// update control; per-window compare and strobes live in woi_win_cmp.
module woi_det_multi
    import woi_pkg::*;
#(
    parameter int unsigned NUM_WIN = NumWinDefault,
    parameter int unsigned CW      = CwDefault,
    parameter int unsigned FW      = FwDefault
) (
    input logic            clk,
    input logic            rst_n,
    woi_det_multi_if.slave vid_io
);

    localparam logic [CW-1:0] CoordMax = '1;

    logic          active;
    logic          load_now;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col1_q, row1_q;
    logic          active1_q;
    logic          vblank_q;
    logic          pending_q, pending_d;
    logic [FW-1:0] frame_q;

    assign active   = ~vid_io.vblank & ~vid_io.hblank;
    assign load_now = vid_io.vblank & pending_q;

    always_comb begin
        col_d = '0;
        if (active) col_d = (col_q == CoordMax) ? col_q : col_q + 1'b1;
        row_d = row_q;
        if (vid_io.vblank) begin
            row_d = '0;
        end else if (active1_q && !active && (row_q != CoordMax)) begin
            row_d = row_q + 1'b1;
        end
        pending_d = load_now ? 1'b0 : (pending_q | vid_io.cfg_load);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            col1_q    <= '0;
            row1_q    <= '0;
            active1_q <= 1'b0;
            // Held high so a reset released during blanking is not counted as a frame.
            vblank_q  <= 1'b1;
            pending_q <= 1'b0;
            frame_q   <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            col1_q    <= col_q;
            row1_q    <= row_q;
            active1_q <= active;
            vblank_q  <= vid_io.vblank;
            pending_q <= pending_d;
            if (vid_io.vblank && !vblank_q) frame_q <= frame_q + 1'b1;
        end
    end

    assign vid_io.cfg_pending = pending_q;
    assign vid_io.frame_cnt   = frame_q;

    for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
        localparam int unsigned Lsb = coord_lsb(unsigned'(i), CW);

        woi_win_cmp #(
            .CW (CW)
        ) u_cmp (
            .clk          (clk),
            .rst_n        (rst_n),
            .load_i       (load_now),
            .cfg_x0_i     (vid_io.cfg_x0[Lsb +: CW]),
            .cfg_x1_i     (vid_io.cfg_x1[Lsb +: CW]),
            .cfg_y0_i     (vid_io.cfg_y0[Lsb +: CW]),
            .cfg_y1_i     (vid_io.cfg_y1[Lsb +: CW]),
            .cfg_en_i     (vid_io.cfg_en[i]),
            .active_i     (active),
            .col_i        (col_q),
            .row_i        (row_q),
            .col1_i       (col1_q),
            .row1_i       (row1_q),
            .win_active_o (vid_io.win_active[i]),
            .win_sow_o    (vid_io.win_sow[i]),
            .win_eol_o    (vid_io.win_eol[i]),
            .win_eow_o    (vid_io.win_eow[i]),
            .win_x_o      (vid_io.win_x[Lsb +: CW]),
            .win_y_o      (vid_io.win_y[Lsb +: CW]),
            .cfg_err_o    (vid_io.cfg_err[i])
        );
    end

endmodule
